nonrestoring_div: RTL and testbench

Multi-cycle divider, parameterised width, built around the team's ripple add/sub datapath. Computes quotient and remainder with a non-restoring algorithm: one add or subtract of the divisor per cycle, selected by the sign of the partial remainder. It inverts the multiply path and sits beside the add/sub unit in the arithmetic block. It presents a start/busy/done handshake to the controlling FSM.

---
 rtl/nonrestoring_div_if.sv | 23 ++
 rtl/nonrestoring_div.sv | 126 ++++++++++++
 tb/tb_nonrestoring_div.sv | 138 +++++++++++++
 3 files changed

// File: rtl/nonrestoring_div_if.sv
// Start/busy/done handshake and operand/result bus between a controlling FSM and the divider.
interface nonrestoring_div_if #(
  parameter int WIDTH = 5
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/nonrestoring_div.sv
// Non-restoring divider, one add/sub per cycle: WIDTH+1 cycle latency, start ignored while busy.
// Define DIV_SIGNED_EN for two's complement operands (truncating quotient, remainder follows dividend).
module nonrestoring_div #(
  parameter int WIDTH = 5
) (
  input logic              clk,
  input logic              rst,
  nonrestoring_div_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH:0]   p;
  logic [WIDTH-1:0] q, d;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] quo_r, rem_r;
  logic             dbz_r;
  logic             busy_c, done_c;
  logic             accept, last;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   p_sh, p_step;
  logic [WIDTH-1:0] q_step, rem_u, quo_fin, rem_fin;
`ifdef DIV_SIGNED_EN
  logic             neg_q, neg_r;
`endif

  assign accept = (state != RUN) && bus.start;
  assign last   = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy_c    = 1'b0;
    done_c    = 1'b0;
    case (state)
      IDLE, DONE: begin
        done_c = (state == DONE);
        if (bus.start) state_nxt = (bus.divisor == '0) ? DONE : RUN;
        else           state_nxt = IDLE;
      end
      RUN: begin
        busy_c = 1'b1;
        if (last) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Core works on magnitudes; signs are reapplied when results are registered.
  always_comb begin
`ifdef DIV_SIGNED_EN
    a_mag = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
    b_mag = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
`else
    a_mag = bus.dividend;
    b_mag = bus.divisor;
`endif
  end

  // Sign of the old partial remainder picks add vs subtract; the WIDTH+1-bit
  // result always lands in [-D, D), so wrap in the shifted value is harmless.
  always_comb begin
    p_sh   = {p[WIDTH-1:0], q[WIDTH-1]};
    p_step = p[WIDTH] ? (p_sh + {1'b0, d}) : (p_sh - {1'b0, d});
    q_step = {q[WIDTH-2:0], ~p_step[WIDTH]};
    rem_u  = p_step[WIDTH] ? (p_step[WIDTH-1:0] + d) : p_step[WIDTH-1:0];
`ifdef DIV_SIGNED_EN
    quo_fin = neg_q ? -q_step : q_step;
    rem_fin = neg_r ? -rem_u  : rem_u;
`else
    quo_fin = q_step;
    rem_fin = rem_u;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p     <= '0;
      q     <= '0;
      d     <= '0;
      cnt   <= '0;
      quo_r <= '0;
      rem_r <= '0;
      dbz_r <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q <= 1'b0;
      neg_r <= 1'b0;
`endif
    end else if (accept) begin
      p   <= '0;
      q   <= a_mag;
      d   <= b_mag;
      cnt <= '0;
`ifdef DIV_SIGNED_EN
      neg_q <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
      neg_r <= bus.dividend[WIDTH-1];
`endif
      if (bus.divisor == '0) begin
        quo_r <= '1;
        rem_r <= bus.dividend;
        dbz_r <= 1'b1;
      end
    end else if (state == RUN) begin
      p   <= p_step;
      q   <= q_step;
      cnt <= cnt + 1'b1;
      if (last) begin
        quo_r <= quo_fin;
        rem_r <= rem_fin;
        dbz_r <= 1'b0;
      end
    end
  end

  assign bus.busy        = busy_c;
  assign bus.done        = done_c;
  assign bus.quotient    = quo_r;
  assign bus.remainder   = rem_r;
  assign bus.div_by_zero = dbz_r;
endmodule

// File: tb/tb_nonrestoring_div.sv
// Directed checks of the divider handshake, timing, results and reset behaviour.
module tb_nonrestoring_div;
  localparam int W = 5;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  nonrestoring_div_if #(.WIDTH(W)) bus ();
  nonrestoring_div #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

`ifdef DIV_SIGNED_EN
  localparam logic [W-1:0] Q27_5 = 5'd31, R27_5 = 5'd0;   // -5 / 5
  localparam logic [W-1:0] Q18_4 = 5'd29, R18_4 = 5'd30;  // -14 / 4
`else
  localparam logic [W-1:0] Q27_5 = 5'd5,  R27_5 = 5'd2;
  localparam logic [W-1:0] Q18_4 = 5'd4,  R18_4 = 5'd2;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic eb, input logic ed,
                     input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez);
    total += 5;
    assert (bus.busy === eb) else begin
      bad++; $error("FAIL %s busy observed=%b expected=%b", tag, bus.busy, eb);
    end
    assert (bus.done === ed) else begin
      bad++; $error("FAIL %s done observed=%b expected=%b", tag, bus.done, ed);
    end
    assert (bus.quotient === eq) else begin
      bad++; $error("FAIL %s quotient observed=%0d expected=%0d", tag, bus.quotient, eq);
    end
    assert (bus.remainder === er) else begin
      bad++; $error("FAIL %s remainder observed=%0d expected=%0d", tag, bus.remainder, er);
    end
    assert (bus.div_by_zero === ez) else begin
      bad++; $error("FAIL %s div_by_zero observed=%b expected=%b", tag, bus.div_by_zero, ez);
    end
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    tick();
    bus.start    = 1'b0;
    bus.dividend = 5'h15;
    bus.divisor  = 5'h0a;
  endtask

  initial begin
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset", 0, 0, 0, 0, 0);

    // 27 / 5: busy cycles 1..5, done in cycle 6, results held during RUN
    issue(5'd27, 5'd5);
    for (int c = 1; c <= 5; c++) begin
      chk($sformatf("div27_5_run%0d", c), 1, 0, 0, 0, 0);
      tick();
    end
    chk("div27_5_done", 0, 1, Q27_5, R27_5, 0);
    tick();
    chk("div27_5_hold", 0, 0, Q27_5, R27_5, 0);

    // 31 / 1 then 3 / 9 accepted in the done cycle
    issue(5'd31, 5'd1);
    repeat (5) tick();
    chk("div31_1_done", 0, 1, 5'd31, 5'd0, 0);
    issue(5'd3, 5'd9);
    chk("b2b_busy", 1, 0, 5'd31, 5'd0, 0);
    repeat (5) tick();
    chk("div3_9_done", 0, 1, 5'd0, 5'd3, 0);

    // divide by zero: immediate done, flag held after done falls
    tick();
    issue(5'd7, 5'd0);
    chk("div7_0_done", 0, 1, 5'd31, 5'd7, 1);
    tick();
    chk("div7_0_hold", 0, 0, 5'd31, 5'd7, 1);
    issue(5'd7, 5'd7);
    chk("div7_7_run", 1, 0, 5'd31, 5'd7, 1);
    repeat (5) tick();
    chk("div7_7_done", 0, 1, 5'd1, 5'd0, 0);

    // start with 20 / 3 pulsed during RUN cycle 2 of 18 / 4 is ignored
    tick();
    issue(5'd18, 5'd4);
    tick();
    bus.start    = 1'b1;
    bus.dividend = 5'd20;
    bus.divisor  = 5'd3;
    tick();
    bus.start = 1'b0;
    chk("ignore_run3", 1, 0, 5'd1, 5'd0, 0);
    repeat (3) tick();
    chk("div18_4_done", 0, 1, Q18_4, R18_4, 0);
    tick();
    chk("div18_4_after", 0, 0, Q18_4, R18_4, 0);

    // synchronous reset in RUN cycle 3
    issue(5'd20, 5'd3);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_run", 0, 0, 0, 0, 0);
    for (int c = 0; c < 8; c++) begin
      tick();
      chk($sformatf("rst_idle%0d", c), 0, 0, 0, 0, 0);
    end

`ifdef DIV_SIGNED_EN
    issue(5'b10011, 5'd4);
    repeat (5) tick();
    chk("sdiv_m13_4", 0, 1, 5'b11101, 5'b11111, 0);
    issue(5'b10000, 5'b11111);
    repeat (5) tick();
    chk("sdiv_m16_m1", 0, 1, 5'b10000, 5'b00000, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
